// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the universal shift register:
//   - shift_mode_e  : encoding of the 2-bit mode input
//   - shift_state_e : state encoding of the burst engine FSM
//   - DIR_RIGHT / DIR_LEFT : meaning of the direction input
// -----------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_LOGIC = 2'b00,  // logical shift, vacated bit filled from serial_input
        MODE_ROT   = 2'b01,  // rotate, bit shifted out re-enters at the other end
        MODE_ARITH = 2'b10,  // arithmetic: sign-extend on right, zero-fill on left
        MODE_HOLD  = 2'b11   // register and serial_out keep their value
    } shift_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage : shift_pkg

// File: rtl/shift_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Purely combinational single-step shifter. The top level uses one instance
// for both the single-step (shift_en) path and the burst engine.
//
// Ports:
//   q            in   WIDTH  current register contents
//   mode         in   2      MODE_LOGIC / MODE_ROT / MODE_ARITH / MODE_HOLD
//   direction    in   1      DIR_RIGHT (0) or DIR_LEFT (1)
//   serial_input in   1      fill bit, used by logical shifts only
//   next_q       out  WIDTH  contents after one step (equal to q in hold)
//   out_bit      out  1      bit leaving the register on this step
//   shifted      out  1      low in hold mode: the caller must not update
//                            its serial output from out_bit
// -----------------------------------------------------------------------------
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    input  logic             direction,
    input  logic             serial_input,
    output logic [WIDTH-1:0] next_q,
    output logic             out_bit,
    output logic             shifted
);

    logic fill;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case/if leaves a signal unassigned and no latch is inferred.
        fill    = 1'b0;
        next_q  = q;
        shifted = 1'b1;
        // Whatever the mode, the departing bit is the end the data moves towards.
        out_bit = (direction == DIR_LEFT) ? q[WIDTH-1] : q[0];

        case (shift_mode_e'(mode))
            MODE_LOGIC: fill = serial_input;
            MODE_ROT:   fill = out_bit;
            // Right: replicate the sign bit. Left: zero-fill.
            MODE_ARITH: fill = (direction == DIR_LEFT) ? 1'b0 : q[WIDTH-1];
            default:    shifted = 1'b0;
        endcase

        if (shifted) begin
            if (direction == DIR_LEFT) begin
                next_q = {q[WIDTH-2:0], fill};
            end else begin
                next_q = {fill, q[WIDTH-1:1]};
            end
        end
    end

endmodule : shift_step

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
// Parametrised universal shift register with parallel load, single-step shift
// and a burst engine that performs shift_count single shifts back to back.
//
// Ports:
//   clk            in   1      rising-edge clock
//   reset          in   1      synchronous, active-high; abandons any burst
//   load           in   1      parallel load request (idle only)
//   parallel_load  in   WIDTH  value loaded on an accepted load
//   mode           in   2      00 logical, 01 rotate, 10 arithmetic, 11 hold
//   direction      in   1      0 shift right, 1 shift left
//   serial_input   in   1      fill bit for logical shifts (sampled live)
//   shift_en       in   1      single-step shift request (idle only)
//   start          in   1      start a burst of shift_count shifts (idle only)
//   shift_count    in   CNT_W  burst length; 0 gives an immediate done pulse
//   parallel_out   out  WIDTH  register contents
//   serial_out     out  1      bit shifted out by the most recent real shift
//   busy           out  1      high while a burst is in progress
//   done           out  1      one-cycle pulse after the last burst shift
//
// Idle priority is load > start > shift_en. During a burst the mode and
// direction captured at start are used; load/start/shift_en are ignored.
// -----------------------------------------------------------------------------
module universal_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] parallel_load,
    input  logic [1:0]       mode,
    input  logic             direction,
    input  logic             serial_input,
    input  logic             shift_en,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_count,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    shift_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_lat_q, mode_lat_d;
    logic             dir_lat_q, dir_lat_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Shared shifter: the burst uses the captured controls, single steps the
    // live ones.
    logic             in_burst;
    logic [1:0]       step_mode;
    logic             step_dir;
    logic [WIDTH-1:0] step_q;
    logic             step_bit;
    logic             step_shifted;

    assign in_burst  = (state_q == ST_SHIFT);
    assign step_mode = in_burst ? mode_lat_q : mode;
    assign step_dir  = in_burst ? dir_lat_q  : direction;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q            (data_q),
        .mode         (step_mode),
        .direction    (step_dir),
        .serial_input (serial_input),
        .next_q       (step_q),
        .out_bit      (step_bit),
        .shifted      (step_shifted)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_lat_d = mode_lat_q;
        dir_lat_d  = dir_lat_q;
        data_d     = data_q;
        sout_d     = sout_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    data_d = parallel_load;
                end else if (start) begin
                    if (shift_count == '0) begin
                        // Empty burst: report completion without shifting.
                        done_d = 1'b1;
                    end else begin
                        // No shift on the start edge; shifts begin next edge.
                        cnt_d      = shift_count;
                        mode_lat_d = mode;
                        dir_lat_d  = direction;
                        state_d    = ST_SHIFT;
                    end
                end else if (shift_en) begin
                    data_d = step_q;
                    if (step_shifted) begin
                        sout_d = step_bit;
                    end
                end
            end

            ST_SHIFT: begin
                // Hold mode still consumes a count: step_q equals data_q there.
                data_d = step_q;
                if (step_shifted) begin
                    sout_d = step_bit;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated only with non-blocking assignments so every
        // flop samples the pre-edge values computed by the always_comb above.
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mode_lat_q <= MODE_LOGIC;
            dir_lat_q  <= DIR_RIGHT;
            data_q     <= '0;
            sout_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_lat_q <= mode_lat_d;
            dir_lat_q  <= dir_lat_d;
            data_q     <= data_d;
            sout_q     <= sout_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign parallel_out = data_q;
    assign serial_out   = sout_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule : universal_shift_reg

// File: tb/tb_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_reg
// Directed scenarios followed by randomized traffic, all compared against a
// cycle-level reference model that computes each shift with integer
// arithmetic and tracks bursts as a remaining-shift count.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int TOP   = 1 << (WIDTH - 1);
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] parallel_load;
    logic [1:0]       mode;
    logic             direction;
    logic             serial_input;
    logic             shift_en;
    logic             start;
    logic [CNT_W-1:0] shift_count;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    universal_shift_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .parallel_load (parallel_load),
        .mode          (mode),
        .direction     (direction),
        .serial_input  (serial_input),
        .shift_en      (shift_en),
        .start         (start),
        .shift_count   (shift_count),
        .parallel_out  (parallel_out),
        .serial_out    (serial_out),
        .busy          (busy),
        .done          (done)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state.
    int m_q, m_so, m_busy, m_done, m_rem, m_mode, m_dir;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One shift by arithmetic on the integer value; hold leaves everything alone.
    task automatic ref_shift(input int md, input int dr, input int si);
        int nq;
        int ob;
        if (md == 3) return;
        if (dr == 0) begin
            ob = m_q % 2;
            case (md)
                0:       nq = (m_q / 2) + si * TOP;
                1:       nq = (m_q / 2) + ob * TOP;
                default: nq = (m_q / 2) + (m_q / TOP) * TOP;
            endcase
        end else begin
            ob = m_q / TOP;
            case (md)
                0:       nq = ((m_q * 2) & MASK) + si;
                1:       nq = ((m_q * 2) & MASK) + ob;
                default: nq = (m_q * 2) & MASK;
            endcase
        end
        m_q  = nq;
        m_so = ob;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        if (reset) begin
            m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_rem = 0;
        end else if (m_busy != 0) begin
            ref_shift(m_mode, m_dir, int'(serial_input));
            m_rem--;
            m_done = (m_rem == 0) ? 1 : 0;
            m_busy = (m_rem == 0) ? 0 : 1;
        end else begin
            m_done = 0;
            if (load) begin
                m_q = int'(parallel_load);
            end else if (start) begin
                if (shift_count == 0) begin
                    m_done = 1;
                end else begin
                    m_busy = 1;
                    m_rem  = int'(shift_count);
                    m_mode = int'(mode);
                    m_dir  = int'(direction);
                end
            end else if (shift_en) begin
                ref_shift(int'(mode), int'(direction), int'(serial_input));
            end
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".q"},    parallel_out, m_q);
        check({tag, ".so"},   serial_out,   m_so);
        check({tag, ".busy"}, busy,         m_busy);
        check({tag, ".done"}, done,         m_done);
    endtask

    task automatic idle_inputs();
        load = 0; start = 0; shift_en = 0;
    endtask

    initial begin
        m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_rem = 0; m_mode = 0; m_dir = 0;
        reset = 1; load = 0; parallel_load = '0; mode = '0; direction = 0;
        serial_input = 0; shift_en = 0; start = 0; shift_count = '0;

        // Reset held two cycles with random inputs.
        for (int i = 0; i < 2; i++) begin
            load = 1'($urandom); start = 1'($urandom); shift_en = 1'($urandom);
            parallel_load = WIDTH'($urandom); mode = 2'($urandom);
            shift_count = CNT_W'($urandom);
            tick("reset");
        end
        check("reset_q", parallel_out, 8'h00);
        check("reset_busy", busy, 1'b0);
        reset = 0;
        idle_inputs();

        // Load A5 then one logical right shift filling a 1.
        load = 1; parallel_load = 8'hA5; tick("load_a5");
        load = 0; shift_en = 1; mode = 2'b00; direction = 0; serial_input = 1;
        tick("lsr");
        check("lsr_q", parallel_out, 8'hD2);
        check("lsr_so", serial_out, 1'b1);
        check("lsr_done", done, 1'b0);
        shift_en = 0;

        // Rotate-left burst of 3 from 81.
        load = 1; parallel_load = 8'h81; tick("load_81");
        load = 0; start = 1; shift_count = 4'd3; mode = 2'b01; direction = 1;
        tick("rot_start");
        check("rot_start_busy", busy, 1'b1);
        check("rot_start_q", parallel_out, 8'h81);
        start = 0;
        tick("rot1"); check("rot1_q", parallel_out, 8'h03);
        tick("rot2"); check("rot2_q", parallel_out, 8'h06);
        tick("rot3"); check("rot3_q", parallel_out, 8'h0C);
        check("rot3_done", done, 1'b1);
        check("rot3_busy", busy, 1'b0);
        tick("rot_after"); check("rot_after_done", done, 1'b0);

        // Arithmetic-right burst of 2 from 90 with a load attempted while busy.
        load = 1; parallel_load = 8'h90; tick("load_90");
        load = 0; start = 1; shift_count = 4'd2; mode = 2'b10; direction = 0;
        tick("asr_start");
        start = 0; load = 1; parallel_load = 8'h00;
        tick("asr1");
        tick("asr2");
        check("asr_q", parallel_out, 8'hE4);
        check("asr_done", done, 1'b1);
        load = 0;

        // Empty burst, then a new start accepted in the done cycle.
        start = 1; shift_count = 4'd0;
        tick("zero_start");
        check("zero_busy", busy, 1'b0);
        check("zero_done", done, 1'b1);
        check("zero_q", parallel_out, 8'hE4);
        shift_count = 4'd1; mode = 2'b01; direction = 0;
        tick("redo_start");
        check("redo_busy", busy, 1'b1);
        start = 0;
        tick("redo1");
        check("redo_q", parallel_out, 8'h72);

        // Rotate by a full WIDTH returns the original value.
        load = 1; parallel_load = 8'h3C; tick("load_3c");
        load = 0; start = 1; shift_count = 4'd8; mode = 2'b01; direction = 1;
        tick("rot8_start");
        start = 0;
        for (int i = 0; i < 8; i++) tick("rot8");
        check("rot8_q", parallel_out, 8'h3C);

        // Reset in the middle of a logical-left burst abandons it.
        load = 1; parallel_load = 8'hFF; tick("load_ff");
        load = 0; start = 1; shift_count = 4'd5; mode = 2'b00; direction = 1; serial_input = 0;
        tick("abort_start");
        start = 0;
        tick("abort1");
        tick("abort2");
        check("abort2_q", parallel_out, 8'hFC);
        reset = 1; tick("abort_reset");
        check("abort_reset_q", parallel_out, 8'h00);
        reset = 0;
        tick("abort_idle");
        check("abort_no_done", done, 1'b0);
        load = 1; parallel_load = 8'h01; tick("load_01");
        load = 0; start = 1; shift_count = 4'd1; tick("one_start");
        start = 0; tick("one1");
        check("one_q", parallel_out, 8'h02);

        // Randomized traffic, including hold-mode bursts and ignored requests.
        for (int i = 0; i < 1500; i++) begin
            reset         = ($urandom_range(0, 63) == 0);
            load          = ($urandom_range(0, 5) == 0);
            start         = ($urandom_range(0, 4) == 0);
            shift_en      = 1'($urandom);
            parallel_load = WIDTH'($urandom);
            mode          = 2'($urandom);
            direction     = 1'($urandom);
            serial_input  = 1'($urandom);
            shift_count   = CNT_W'($urandom);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_universal_shift_reg
